// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, TX arbiter state encoding and the
// default arbiter sizing used as parameter defaults.
package uart_pkg;

    localparam int unsigned UART_DATA_W       = 8;
    localparam int unsigned ARB_NUM_REQ_DEF   = 4;
    localparam int unsigned ARB_MAX_BURST_DEF = 16;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: returns the first set request at or above ptr,
// wrapping around to index 0.
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - starting index of the search
//   pick - one-hot selected requester (all zero when nothing requests)
//   any  - at least one request is set
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = ARB_NUM_REQ_DEF,
    localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               any
);

    // Walk NUM_REQ positions starting at ptr; first hit wins.
    always_comb begin
        int unsigned idx;
        idx  = 0;
        pick = '0;
        any  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req[PTR_W'(idx)]) begin
                pick[PTR_W'(idx)] = 1'b1;
                any               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port among NUM_REQ
// byte-stream requesters. A grant lasts until the owner's last byte or
// until MAX_BURST bytes have been forwarded, whichever comes first.
// Ports:
//   clk, rst    - clock (FIFO write clock), synchronous active-high reset
//   req_valid   - per-requester byte valid
//   req_data    - requester i's byte on [8i+7:8i]
//   req_last    - final byte of the requester's packet
//   req_ready   - per-requester accept (combinational)
//   grant       - one-hot owner, zero when idle (registered)
//   busy        - arbiter is in the GRANT state (registered)
//   fifo_wr_en  - FIFO write strobe (combinational)
//   fifo_din    - FIFO write byte (combinational)
//   fifo_full   - FIFO full flag
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ   = ARB_NUM_REQ_DEF,
    parameter int unsigned MAX_BURST = ARB_MAX_BURST_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic                           fifo_wr_en,
    output logic [UART_DATA_W-1:0]         fifo_din,
    input  logic                           fifo_full
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] pick;
    logic               pick_any;
    logic [PTR_W-1:0]   ptr_after_owner;
    logic               xfer;
    logic               burst_done;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req  (req_valid),
        .ptr  (rr_ptr_q),
        .pick (pick),
        .any  (pick_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
        end
    end

    // Pointer to the requester after the current owner, wrapping explicitly
    // so non-power-of-two NUM_REQ never lands on an unused index.
    always_comb begin
        ptr_after_owner = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                ptr_after_owner = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Next state and combinational write-path outputs
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        req_ready   = '0;
        fifo_wr_en  = 1'b0;
        fifo_din    = '0;
        xfer        = 1'b0;
        burst_done  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d     = pick;
                    burst_cnt_d = '0;
                    busy_d      = 1'b1;
                    state_d     = ARB_GRANT;
                end
            end

            ARB_GRANT: begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (grant_q[i]) begin
                        fifo_din = req_data[i*UART_DATA_W +: UART_DATA_W];
                    end
                end
                req_ready  = grant_q & {NUM_REQ{~fifo_full}};
                xfer       = (|(grant_q & req_valid)) & ~fifo_full;
                fifo_wr_en = xfer;

                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    // Release on the owner's last byte or when this byte fills the burst.
                    burst_done  = (|(grant_q & req_last)) ||
                                  ((burst_cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST));
                    if (burst_done) begin
                        grant_d  = '0;
                        busy_d   = 1'b0;
                        rr_ptr_d = ptr_after_owner;
                        state_d  = ARB_IDLE;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=16): a cycle table with
// hand-driven inputs, then queue-driven requesters checked by a scoreboard.
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0] req_last = '0;
    logic [NR-1:0] req_ready;
    logic [NR-1:0] grant;
    logic          busy;
    logic          fifo_wr_en;
    logic [7:0]    fifo_din;
    logic          fifo_full = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ   (4),
        .MAX_BURST (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .busy       (busy),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        int         req;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  grant;
        logic        busy;
        logic [3:0]  ready;
        logic        wr;
        logic [7:0]  din;
    } vec_t;

    beat_t src_q [NR][$];
    exp_t  sb[$];
    int    wr_cyc[$];
    vec_t  vecs[17];

    int tests    = 0;
    int fails    = 0;
    int wr_count = 0;
    int cyc      = 0;
    int mark     = 0;

    bit          manual    = 1'b1;
    logic [3:0]  man_valid = '0;
    logic [31:0] man_data  = '0;
    logic [3:0]  man_last  = '0;
    logic [3:0]  gap       = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (wr_count < target && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (wr_count < target) begin
            fails++;
            $display("FAIL %s: timed out with %0d writes, expected %0d", name, wr_count, target);
        end
    endtask

    task automatic expect_run(input int r, input int n, input logic [7:0] base);
        for (int j = 0; j < n; j++) begin
            sb.push_back('{req: r, data: 8'(base + 8'(j))});
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester model: inputs change 2 time units after the active edge.
    always @(posedge clk) begin
        #2;
        if (manual) begin
            req_valid = man_valid;
            req_data  = man_data;
            req_last  = man_last;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (src_q[i].size() > 0 && !gap[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[i*8 +: 8] = src_q[i][0].data;
                    req_last[i]        = src_q[i][0].last;
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[i*8 +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // FIFO-side scoreboard and requester handshake tracking.
    always @(negedge clk) begin
        exp_t e;
        if (!manual) begin
            if (fifo_wr_en) begin
                wr_count++;
                wr_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got byte 0x%0h from grant %b, expected no write", fifo_din, grant);
                end else begin
                    e = sb.pop_front();
                    check("wr_data", 32'(fifo_din), 32'(e.data));
                    check("wr_owner", 32'(grant), 32'(1) << e.req);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    src_q[i].delete(0);
                end
            end
        end
    end

    initial begin
        //          valid    data          last     full  grant    busy  ready    wr    din
        vecs[0]  = '{4'b0001, 32'h00000041, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[1]  = '{4'b0001, 32'h00000041, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h41};
        vecs[2]  = '{4'b0001, 32'h00000042, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h42};
        vecs[3]  = '{4'b0001, 32'h00000043, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h43};
        vecs[4]  = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[5]  = '{4'b0011, 32'h0000B1AA, 4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[6]  = '{4'b0011, 32'h0000B1AA, 4'b0011, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'hB1};
        vecs[7]  = '{4'b0001, 32'h000000AA, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[8]  = '{4'b0001, 32'h000000AA, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hAA};
        vecs[9]  = '{4'b0100, 32'h00C00000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[10] = '{4'b0100, 32'h00C00000, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0, 8'hC0};
        vecs[11] = '{4'b0100, 32'h00C00000, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC0};
        vecs[12] = '{4'b1111, 32'hD3D2D1D0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[13] = '{4'b1111, 32'hD3D2D1D0, 4'b1111, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'hD3};
        vecs[14] = '{4'b1111, 32'hD3D2D1D0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[15] = '{4'b1111, 32'hD3D2D1D0, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hD0};
        vecs[16] = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};

        // Reset state
        repeat (3) step();
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("rst_din", 32'(fifo_din), 32'h0);
        step();
        rst = 1'b0;

        // Cycle table: single requester, rotation, wrap-around, full in GRANT
        for (int k = 0; k < 17; k++) begin
            step();
            man_valid = vecs[k].valid;
            man_data  = vecs[k].data;
            man_last  = vecs[k].last;
            fifo_full = vecs[k].full;
            @(negedge clk);
            check($sformatf("v%0d_grant", k), 32'(grant), 32'(vecs[k].grant));
            check($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].busy));
            check($sformatf("v%0d_ready", k), 32'(req_ready), 32'(vecs[k].ready));
            check($sformatf("v%0d_wr_en", k), 32'(fifo_wr_en), 32'(vecs[k].wr));
            check($sformatf("v%0d_din", k), 32'(fifo_din), 32'(vecs[k].din));
        end
        step();
        manual = 1'b0;

        // Fairness: all four hold 1-byte packets; pointer sits at 1 after the table
        mark = wr_count;
        for (int r = 0; r < NR; r++) begin
            for (int j = 0; j < 3; j++) begin
                src_q[r].push_back('{data: 8'(8'h80 + 8'(16 * r + j)), last: 1'b1});
            end
        end
        for (int j = 0; j < 3; j++) begin
            sb.push_back('{req: 1, data: 8'(8'h90 + 8'(j))});
            sb.push_back('{req: 2, data: 8'(8'hA0 + 8'(j))});
            sb.push_back('{req: 3, data: 8'(8'hB0 + 8'(j))});
            sb.push_back('{req: 0, data: 8'(8'h80 + 8'(j))});
        end
        wait_writes(mark + 12, 60, "fair_wait");
        if (wr_cyc.size() >= mark + 12) begin
            check("fair_spacing", 32'(wr_cyc[mark + 11] - wr_cyc[mark]), 32'd22);
        end

        // Forced release after 16 bytes; pending req 3 goes before req 2 resumes
        mark = wr_count;
        for (int j = 0; j < 20; j++) begin
            src_q[2].push_back('{data: 8'(8'h20 + 8'(j)), last: (j == 19)});
        end
        src_q[3].push_back('{data: 8'h3F, last: 1'b1});
        expect_run(2, 16, 8'h20);
        expect_run(3, 1, 8'h3F);
        expect_run(2, 4, 8'h30);
        wait_writes(mark + 21, 80, "force_wait");

        // Backpressure: full held for 5 cycles mid-burst
        mark = wr_count;
        for (int j = 0; j < 8; j++) begin
            src_q[3].push_back('{data: 8'(8'h60 + 8'(j)), last: (j == 7)});
        end
        expect_run(3, 8, 8'h60);
        wait_writes(mark + 3, 20, "bp_start");
        fifo_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_wr_en", 32'(fifo_wr_en), 32'h0);
            check("bp_ready", 32'(req_ready), 32'h0);
            check("bp_grant", 32'(grant), 32'h8);
            step();
        end
        fifo_full = 1'b0;
        wait_writes(mark + 8, 30, "bp_wait");

        // Valid gap while granted: req 1 holds the grant, req 0 waits
        mark = wr_count;
        src_q[0].push_back('{data: 8'h50, last: 1'b1});
        expect_run(0, 1, 8'h50);
        wait_writes(mark + 1, 20, "gap_pre");
        mark = wr_count;
        for (int j = 0; j < 6; j++) begin
            src_q[1].push_back('{data: 8'(8'h10 + 8'(j)), last: (j == 5)});
        end
        src_q[0].push_back('{data: 8'h58, last: 1'b0});
        src_q[0].push_back('{data: 8'h59, last: 1'b1});
        expect_run(1, 6, 8'h10);
        expect_run(0, 2, 8'h58);
        wait_writes(mark + 2, 20, "gap_start");
        gap[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("gap_grant", 32'(grant), 32'h2);
            check("gap_wr_en", 32'(fifo_wr_en), 32'h0);
            step();
        end
        gap[1] = 1'b0;
        wait_writes(mark + 8, 40, "gap_wait");

        // Reset mid-burst: req 2 loses its grant, pointer returns to 0
        mark = wr_count;
        for (int j = 0; j < 4; j++) begin
            src_q[2].push_back('{data: 8'(8'hE0 + 8'(j)), last: (j == 3)});
        end
        expect_run(2, 2, 8'hE0);
        wait_writes(mark + 1, 20, "rst_start");
        rst = 1'b1;
        src_q[1].push_back('{data: 8'h71, last: 1'b1});
        step();
        src_q[2].delete();
        src_q[2].push_back('{data: 8'h72, last: 1'b1});
        expect_run(1, 1, 8'h71);
        expect_run(2, 1, 8'h72);
        @(negedge clk);
        check("mid_rst_grant", 32'(grant), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_wr_en", 32'(fifo_wr_en), 32'h0);
        step();
        rst = 1'b0;
        wait_writes(mark + 4, 20, "rst_wait");

        repeat (4) step();
        check("sb_drained", 32'(sb.size()), 32'h0);
        check("src_drained", 32'(src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
